// File: rtl/clk_tick_gen_if.sv
// Control/status bundle for clk_tick_gen: enable, prescaler reload request,
// and the strobe/index/level outputs consumed by downstream clk-domain logic.
interface clk_tick_gen_if #(
  parameter int unsigned CNT_W = 30,
  parameter int unsigned IDX_W = 2
) ();
  logic             en;
  logic [CNT_W-1:0] prs_div;
  logic             prs_load;
  logic             scan_tick;
  logic [IDX_W-1:0] scan_idx;
  logic             prs_tick;
  logic             prs_lvl;
  logic [CNT_W-1:0] prs_div_q;
  logic             prs_pend;

  modport master (
    output en, prs_div, prs_load,
    input  scan_tick, scan_idx, prs_tick, prs_lvl, prs_div_q, prs_pend
  );

  modport slave (
    input  en, prs_div, prs_load,
    output scan_tick, scan_idx, prs_tick, prs_lvl, prs_div_q, prs_pend
  );
endinterface

// File: rtl/clk_tick_gen.sv
// Timing generator: scan strobe with modulo-DIGITS index, and a reloadable
// prescaler whose new divisor only takes effect at a period boundary.
module clk_tick_gen #(
  parameter int unsigned CNT_W       = 30,
  parameter int unsigned SCAN_DIV    = 262144,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned PRS_DIV_RST = 524288
) (
  input  logic           clk,
  input  logic           rst,
  clk_tick_gen_if.slave  bus
);

  localparam logic [CNT_W-1:0] SC_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] PRS_RST  = CNT_W'(PRS_DIV_RST);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [CNT_W-1:0] r_sc_cnt;
  logic [IDX_W-1:0] r_scan_idx;
  logic             r_scan_tick;

  logic [CNT_W-1:0] r_pr_cnt;
  logic             r_prs_tick;
  logic             r_prs_lvl;
  logic [CNT_W-1:0] r_prs_div_q;
  logic [CNT_W-1:0] r_prs_shadow;
  logic             r_prs_pend;

  logic             w_sc_term;
  logic             w_pr_term;
  logic [CNT_W-1:0] w_div_clamped;

  // Terminal counts only qualify while enabled, so a frozen counter sitting
  // on its last value neither ticks nor swaps the divisor.
  always_comb begin
    w_sc_term     = bus.en && (r_sc_cnt == SC_LAST);
    w_pr_term     = bus.en && (r_pr_cnt == (r_prs_div_q - CNT_ONE));
    w_div_clamped = (bus.prs_div == '0) ? CNT_ONE : bus.prs_div;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sc_cnt    <= '0;
      r_scan_idx  <= '0;
      r_scan_tick <= 1'b0;
    end else if (bus.en) begin
      if (w_sc_term) begin
        r_sc_cnt    <= '0;
        r_scan_tick <= 1'b1;
        r_scan_idx  <= (r_scan_idx == IDX_LAST) ? '0 : r_scan_idx + IDX_ONE;
      end else begin
        r_sc_cnt    <= r_sc_cnt + CNT_ONE;
        r_scan_tick <= 1'b0;
      end
    end else begin
      r_scan_tick <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pr_cnt   <= '0;
      r_prs_tick <= 1'b0;
      r_prs_lvl  <= 1'b0;
    end else if (bus.en) begin
      if (w_pr_term) begin
        r_pr_cnt   <= '0;
        r_prs_tick <= 1'b1;
        r_prs_lvl  <= ~r_prs_lvl;
      end else begin
        r_pr_cnt   <= r_pr_cnt + CNT_ONE;
        r_prs_tick <= 1'b0;
      end
    end else begin
      r_prs_tick <= 1'b0;
    end
  end

  // A load coinciding with the boundary bypasses the shadow and lands
  // directly; otherwise it waits in the shadow until the next boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prs_div_q  <= PRS_RST;
      r_prs_shadow <= '0;
      r_prs_pend   <= 1'b0;
    end else if (w_pr_term) begin
      if (bus.prs_load) begin
        r_prs_div_q <= w_div_clamped;
        r_prs_pend  <= 1'b0;
      end else if (r_prs_pend) begin
        r_prs_div_q <= r_prs_shadow;
        r_prs_pend  <= 1'b0;
      end
    end else if (bus.prs_load) begin
      r_prs_shadow <= w_div_clamped;
      r_prs_pend   <= 1'b1;
    end
  end

  assign bus.scan_tick = r_scan_tick;
  assign bus.scan_idx  = r_scan_idx;
  assign bus.prs_tick  = r_prs_tick;
  assign bus.prs_lvl   = r_prs_lvl;
  assign bus.prs_div_q = r_prs_div_q;
  assign bus.prs_pend  = r_prs_pend;

endmodule

// File: tb/tb_clk_tick_gen.sv
// Bench for clk_tick_gen (CNT_W=8, SCAN_DIV=4, DIGITS=3, PRS_DIV_RST=5):
// directed scenarios plus random traffic, all checked against a period model.
module tb_clk_tick_gen;

  localparam int SDIV = 4;
  localparam int NDIG = 3;
  localparam int PRST = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  clk_tick_gen_if #(.CNT_W(8), .IDX_W(2)) bus ();

  clk_tick_gen #(
    .CNT_W(8), .SCAN_DIV(SDIV), .DIGITS(NDIG), .IDX_W(2), .PRS_DIV_RST(PRST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: enabled-cycle total drives the scan side; the prescaler is
  // tracked as a position inside a period of the current length.
  int m_en_total, m_pos, m_div, m_shadow, m_idx;
  bit m_stick, m_ptick, m_lvl, m_pend;

  task automatic model_step(input bit r, input bit e, input bit l, input int d);
    bit last;
    int nv;
    if (r) begin
      m_en_total = 0; m_pos = 0; m_div = PRST; m_shadow = 0; m_idx = 0;
      m_stick = 0; m_ptick = 0; m_lvl = 0; m_pend = 0;
    end else begin
      last = e && (m_pos + 1 == m_div);
      nv   = (d == 0) ? 1 : d;
      if (e) begin
        m_en_total++;
        m_stick = (m_en_total % SDIV) == 0;
        m_idx   = (m_en_total / SDIV) % NDIG;
        m_pos   = last ? 0 : m_pos + 1;
      end else begin
        m_stick = 0;
      end
      m_ptick = last;
      if (last) m_lvl = !m_lvl;
      if (last) begin
        if (l) begin m_div = nv; m_pend = 0; end
        else if (m_pend) begin m_div = m_shadow; m_pend = 0; end
      end else if (l) begin
        m_shadow = nv; m_pend = 1;
      end
    end
  endtask

  function automatic logic [13:0] exp_vec();
    logic [1:0] ix;
    logic [7:0] dv;
    ix = m_idx[1:0];
    dv = m_div[7:0];
    return {m_stick, ix, m_ptick, m_lvl, dv, m_pend};
  endfunction

  function automatic logic [13:0] act_vec();
    return {bus.scan_tick, bus.scan_idx, bus.prs_tick, bus.prs_lvl, bus.prs_div_q, bus.prs_pend};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step(rst, bus.en, bus.prs_load, int'(bus.prs_div));
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.en = 1'b0; bus.prs_load = 1'b0; bus.prs_div = '0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (act_vec() !== {1'b0, 2'd0, 1'b0, 1'b0, 8'd5, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_state: got %b expected %b", act_vec(), {1'b0, 2'd0, 1'b0, 1'b0, 8'd5, 1'b0});
    end
  endtask

  task automatic test_free_run();
    do_reset();
    bus.en = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      cyc();
      n_checks++;
      if (bus.scan_tick !== ((k % 4) == 0) || bus.scan_idx !== 2'((k / 4) % 3)) begin
        n_errors++;
        $display("FAIL free_scan k=%0d: tick=%b idx=%0d expected tick=%b idx=%0d",
                 k, bus.scan_tick, bus.scan_idx, (k % 4) == 0, (k / 4) % 3);
      end
      n_checks++;
      if (bus.prs_tick !== ((k % 5) == 0) || bus.prs_lvl !== (((k / 5) % 2) == 1)) begin
        n_errors++;
        $display("FAIL free_prs k=%0d: tick=%b lvl=%b expected tick=%b lvl=%b",
                 k, bus.prs_tick, bus.prs_lvl, (k % 5) == 0, ((k / 5) % 2) == 1);
      end
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL free_model k=%0d: got %b expected %b", k, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_load_pending();
    do_reset();
    bus.en = 1'b1;
    cyc(); cyc();
    bus.prs_load = 1'b1; bus.prs_div = 8'd2;
    cyc();
    bus.prs_load = 1'b0;
    n_checks++;
    if (bus.prs_pend !== 1'b1 || bus.prs_div_q !== 8'd5) begin
      n_errors++;
      $display("FAIL load_pend_set: pend=%b div_q=%0d expected pend=1 div_q=5", bus.prs_pend, bus.prs_div_q);
    end
    cyc(); cyc();
    n_checks++;
    if (bus.prs_tick !== 1'b1 || bus.prs_pend !== 1'b0 || bus.prs_div_q !== 8'd2) begin
      n_errors++;
      $display("FAIL load_pend_swap: tick=%b pend=%b div_q=%0d expected 1 0 2",
               bus.prs_tick, bus.prs_pend, bus.prs_div_q);
    end
    for (int k = 1; k <= 6; k++) begin
      cyc();
      n_checks++;
      if (bus.prs_tick !== ((k % 2) == 0) || act_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL load_pend_run k=%0d: got %b expected %b tick=%b", k, act_vec(), exp_vec(), (k % 2) == 0);
      end
    end
  endtask

  task automatic test_load_at_terminal();
    do_reset();
    bus.en = 1'b1;
    repeat (4) cyc();
    bus.prs_load = 1'b1; bus.prs_div = 8'd3;
    cyc();
    bus.prs_load = 1'b0;
    n_checks++;
    if (bus.prs_tick !== 1'b1 || bus.prs_pend !== 1'b0 || bus.prs_div_q !== 8'd3) begin
      n_errors++;
      $display("FAIL load_term: tick=%b pend=%b div_q=%0d expected 1 0 3",
               bus.prs_tick, bus.prs_pend, bus.prs_div_q);
    end
    for (int k = 1; k <= 6; k++) begin
      cyc();
      n_checks++;
      if (bus.prs_tick !== ((k % 3) == 0) || bus.prs_pend !== 1'b0) begin
        n_errors++;
        $display("FAIL load_term_run k=%0d: tick=%b pend=%b expected tick=%b pend=0",
                 k, bus.prs_tick, bus.prs_pend, (k % 3) == 0);
      end
    end
  endtask

  task automatic test_load_zero();
    logic lvl_prev;
    do_reset();
    bus.en = 1'b1;
    cyc();
    bus.prs_load = 1'b1; bus.prs_div = 8'd0;
    cyc();
    bus.prs_load = 1'b0;
    cyc(); cyc(); cyc();
    n_checks++;
    if (bus.prs_div_q !== 8'd1 || bus.prs_pend !== 1'b0) begin
      n_errors++;
      $display("FAIL load_zero_clamp: div_q=%0d pend=%b expected div_q=1 pend=0", bus.prs_div_q, bus.prs_pend);
    end
    for (int k = 1; k <= 4; k++) begin
      lvl_prev = bus.prs_lvl;
      cyc();
      n_checks++;
      if (bus.prs_tick !== 1'b1 || bus.prs_lvl !== ~lvl_prev) begin
        n_errors++;
        $display("FAIL load_zero_run k=%0d: tick=%b lvl=%b expected tick=1 lvl=%b",
                 k, bus.prs_tick, bus.prs_lvl, ~lvl_prev);
      end
    end
  endtask

  task automatic test_enable_hold();
    logic [1:0] idx_h;
    logic       lvl_h;
    int         n_st, n_pt;
    do_reset();
    bus.en = 1'b1;
    repeat (6) cyc();
    idx_h = bus.scan_idx; lvl_h = bus.prs_lvl;
    bus.en = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      n_checks++;
      if (bus.scan_tick !== 1'b0 || bus.prs_tick !== 1'b0 || bus.scan_idx !== idx_h || bus.prs_lvl !== lvl_h) begin
        n_errors++;
        $display("FAIL en_hold k=%0d: st=%b pt=%b idx=%0d lvl=%b expected 0 0 %0d %b",
                 k, bus.scan_tick, bus.prs_tick, bus.scan_idx, bus.prs_lvl, idx_h, lvl_h);
      end
    end
    bus.en = 1'b1;
    n_st = 0; n_pt = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (bus.scan_tick === 1'b1) n_st++;
      if (bus.prs_tick === 1'b1) n_pt++;
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL en_resume k=%0d: got %b expected %b", k, act_vec(), exp_vec());
      end
    end
    n_checks++;
    if (n_st !== 3 || n_pt !== 2) begin
      n_errors++;
      $display("FAIL en_resume_count: scan=%0d prs=%0d expected scan=3 prs=2", n_st, n_pt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.en = 1'b1;
    cyc(); cyc();
    bus.prs_load = 1'b1; bus.prs_div = 8'd7;
    cyc();
    bus.prs_load = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    n_checks++;
    if (act_vec() !== {1'b0, 2'd0, 1'b0, 1'b0, 8'd5, 1'b0}) begin
      n_errors++;
      $display("FAIL rst_mid: got %b expected %b", act_vec(), {1'b0, 2'd0, 1'b0, 1'b0, 8'd5, 1'b0});
    end
    rst = 1'b0;
    repeat (5) cyc();
    n_checks++;
    if (bus.prs_tick !== 1'b1 || bus.prs_div_q !== 8'd5 || bus.prs_pend !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_mid_after: tick=%b div_q=%0d pend=%b expected 1 5 0",
               bus.prs_tick, bus.prs_div_q, bus.prs_pend);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      rst          = ($urandom_range(0, 149) == 0);
      bus.en       = ($urandom_range(0, 3) != 0);
      bus.prs_load = ($urandom_range(0, 7) == 0);
      bus.prs_div  = 8'($urandom_range(0, 6));
      cyc();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL random k=%0d: got %b expected %b", k, act_vec(), exp_vec());
      end
    end
    rst = 1'b0; bus.prs_load = 1'b0;
  endtask

  initial begin
    bus.en = 1'b0; bus.prs_load = 1'b0; bus.prs_div = '0;
    test_reset();
    test_free_run();
    test_load_pending();
    test_load_at_terminal();
    test_load_zero();
    test_enable_hold();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
